core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 164 ++++++++++++++++
 tb/tb_core_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - instruction sequencer FSM: fetch, decode, execute, memory, write-back, trap.
// All strobes are registered from the next state; only ir_we is combinational.
module core_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        dec_valid,
  input  logic        dec_reg_w,
  input  logic        dec_data_r,
  input  logic        dec_data_w,
  input  logic        dec_branch,
  input  logic        dec_jal,
  input  logic        dec_jalr,
  input  logic        branch_taken,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  cause,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  cause_q, cause_d;
  logic        imem_req_q, imem_req_d;
  logic        alu_en_q, alu_en_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic        pc_we_q, pc_we_d;
  logic [1:0]  pc_sel_q, pc_sel_d;
  logic        retire_q, retire_d;
  logic        trap_q, trap_d;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        // Ack takes precedence over an expiring wait counter.
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (dec_valid) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC:   state_d = (dec_data_r | dec_data_w) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase

    wait_d = (state_d != state_q) ? 8'd0 : wait_q + 8'd1;
    if (state_d != S_FETCH && state_d != S_MEM) wait_d = 8'd0;

    instret_d = (state_q == S_WB) ? instret_q + 32'd1 : instret_q;

    // Decoder flags are stable while the instruction is held, so WB outputs
    // can be computed on the way into WB.
    imem_req_d = (state_d == S_FETCH);
    alu_en_d   = (state_d == S_EXEC);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) & dec_data_w;
    rf_we_d    = (state_d == S_WB) & dec_reg_w & ~dec_data_w & ~dec_branch;
    pc_we_d    = (state_d == S_WB);
    retire_d   = (state_d == S_WB);
    trap_d     = (state_d == S_TRAP);
    pc_sel_d   = 2'b00;
    if (state_d == S_WB) begin
      if (dec_jalr)                              pc_sel_d = 2'b10;
      else if (dec_jal | (dec_branch & branch_taken)) pc_sel_d = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_q     <= 8'd0;
      instret_q  <= 32'd0;
      cause_q    <= 2'b00;
      imem_req_q <= 1'b0;
      alu_en_q   <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      pc_sel_q   <= 2'b00;
      retire_q   <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      instret_q  <= instret_d;
      cause_q    <= cause_d;
      imem_req_q <= imem_req_d;
      alu_en_q   <= alu_en_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      pc_we_q    <= pc_we_d;
      pc_sel_q   <= pc_sel_d;
      retire_q   <= retire_d;
      trap_q     <= trap_d;
    end
  end

  assign state    = state_q;
  assign imem_req = imem_req_q;
  assign ir_we    = imem_req_q & imem_ack;
  assign alu_en   = alu_en_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign rf_we    = rf_we_q;
  assign pc_we    = pc_we_q;
  assign pc_sel   = pc_sel_q;
  assign retire   = retire_q;
  assign instret  = instret_q;
  assign trap     = trap_q;
  assign cause    = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized instruction stream against a cycle-trace reference model.
module tb_core_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n, run, imem_req, imem_ack, ir_we;
  logic        dec_valid, dec_reg_w, dec_data_r, dec_data_w, dec_branch, dec_jal, dec_jalr;
  logic        branch_taken, alu_en, dmem_req, dmem_we, dmem_ack, rf_we, pc_we, retire, trap;
  logic [1:0]  pc_sel, cause;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dec_valid(dec_valid), .dec_reg_w(dec_reg_w), .dec_data_r(dec_data_r),
    .dec_data_w(dec_data_w), .dec_branch(dec_branch), .dec_jal(dec_jal), .dec_jalr(dec_jalr),
    .branch_taken(branch_taken), .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .instret(instret), .trap(trap), .cause(cause), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One expected cycle: state, bus acks and run to drive, cause to expect.
  typedef struct {
    logic [2:0] st;
    logic       ia;
    logic       da;
    logic       rn;
    logic [1:0] cs;
  } step_t;

  step_t       q[$];
  logic [31:0] m_instret;
  bit          m_idle;

  function automatic logic [12:0] exp_outs(input step_t s);
    logic [1:0] ps;
    ps = 2'b00;
    if (s.st == 3'd5) ps = dec_jalr ? 2'b10 : ((dec_jal | (dec_branch & branch_taken)) ? 2'b01 : 2'b00);
    return {s.st == 3'd1, (s.st == 3'd1) && s.ia, s.st == 3'd3, s.st == 3'd4,
            (s.st == 3'd4) && dec_data_w,
            (s.st == 3'd5) && dec_reg_w && !dec_data_w && !dec_branch,
            s.st == 3'd5, ps, s.st == 3'd5, s.st == 3'd6, (s.st == 3'd6) ? s.cs : 2'b00};
  endfunction

  function automatic logic [12:0] act_outs();
    return {imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, trap, cause};
  endfunction

  task automatic play();
    foreach (q[i]) begin
      @(negedge clk);
      run      = q[i].rn;
      imem_ack = q[i].ia;
      dmem_ack = q[i].da;
      #1;
      check_eq("state", 64'(state), 64'(q[i].st));
      check_eq("outs", 64'(act_outs()), 64'(exp_outs(q[i])));
      check_eq("instret", 64'(instret), 64'(m_instret));
      if (q[i].st == 3'd5) m_instret = m_instret + 32'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_outs", 64'(act_outs()), 64'd0);
    check_eq("rst_instret", 64'(instret), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_instret = 32'd0;
    m_idle = 1'b1;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 jalr, 6 illegal.
  task automatic do_instr(input int kind, input int ilat, input int dlat, input bit cont);
    bit trapped;
    step_t s;
    trapped = 1'b0;
    dec_valid = (kind != 6);
    dec_reg_w = 1'b0; dec_data_r = 1'b0; dec_data_w = 1'b0;
    dec_branch = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0;
    branch_taken = 1'($urandom_range(0, 1));
    case (kind)
      0: dec_reg_w = 1'b1;
      1: begin dec_reg_w = 1'b1; dec_data_r = 1'b1; end
      2: begin dec_reg_w = 1'($urandom_range(0, 1)); dec_data_w = 1'b1; end
      3: begin dec_reg_w = 1'($urandom_range(0, 1)); dec_branch = 1'b1; end
      4: begin dec_reg_w = 1'b1; dec_jal = 1'b1; end
      5: begin dec_reg_w = 1'b1; dec_jalr = 1'b1; dec_jal = 1'($urandom_range(0, 1)); end
      default: ;
    endcase
    q.delete();
    if (m_idle) begin s = '{3'd0, 1'b0, 1'b0, 1'b1, 2'b00}; q.push_back(s); end
    for (int k = 0; k < TO; k++) begin
      s = '{3'd1, 1'(k == ilat), 1'b0, cont, 2'b00};
      q.push_back(s);
      if (k == ilat) break;
      if (k == TO - 1) begin trapped = 1'b1; s = '{3'd6, 1'b0, 1'b0, cont, 2'b10}; end
    end
    if (!trapped) begin
      q.push_back('{3'd2, 1'b0, 1'b0, cont, 2'b00});
      if (kind == 6) begin trapped = 1'b1; s = '{3'd6, 1'b0, 1'b0, cont, 2'b01}; end
    end
    if (!trapped) begin
      q.push_back('{3'd3, 1'b0, 1'b0, cont, 2'b00});
      if (kind == 1 || kind == 2) begin
        for (int k = 0; k < TO; k++) begin
          q.push_back('{3'd4, 1'b0, 1'(k == dlat), cont, 2'b00});
          if (k == dlat) break;
          if (k == TO - 1) begin trapped = 1'b1; s = '{3'd6, 1'b0, 1'b0, cont, 2'b11}; end
        end
      end
    end
    if (trapped) begin
      for (int k = 0; k < 20; k++) q.push_back(s);
    end else begin
      q.push_back('{3'd5, 1'b0, 1'b0, cont, 2'b00});
    end
    play();
    if (trapped) do_reset();
    else m_idle = !cont;
  endtask

  function automatic int rand_lat();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    reset_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_valid = 1'b0; dec_reg_w = 1'b0; dec_data_r = 1'b0; dec_data_w = 1'b0;
    dec_branch = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0; branch_taken = 1'b0;
    m_instret = 32'd0; m_idle = 1'b1;
    #2;
    check_eq("por_state", 64'(state), 64'd0);
    check_eq("por_outs", 64'(act_outs()), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_instr(0, 0, 0, 1'b1);
    do_instr(1, 0, 3, 1'b1);
    do_instr(3, 0, 0, 1'b1);
    do_instr(5, 0, 0, 1'b0);
    do_instr(2, 1, 0, 1'b1);
    do_instr(6, 0, 0, 1'b1);
    do_instr(0, TO - 1, 0, 1'b1);
    do_instr(0, TO, 0, 1'b1);
    do_instr(1, 0, TO, 1'b1);
    for (int n = 0; n < 150; n++)
      do_instr(int'($urandom_range(0, 6)), rand_lat(), rand_lat(), 1'($urandom_range(0, 3) != 0));

    do_reset();
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    do_instr(0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    check_eq("wrap_instret", 64'(instret), 64'd0);
    check_eq("wrap_idle", 64'(state), 64'd0);

    dec_valid = 1'b1; dec_reg_w = 1'b1; dec_data_r = 1'b1; dec_data_w = 1'b0;
    dec_branch = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0;
    imem_ack = 1'b1; dmem_ack = 1'b0; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (state == 3'd4) break;
    end
    check_eq("reach_mem", 64'(state), 64'd4);
    check_eq("mem_req_on", 64'(dmem_req), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mem_req_drop", 64'(dmem_req), 64'd0);
    check_eq("mem_rst_state", 64'(state), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
